ft_bus_scheduler: RTL and testbench

FT_BUS_SCHEDULER -- requirements
Module: ft_bus_scheduler

---
 rtl/ft_bus_scheduler_pkg.sv | 36 +++
 rtl/ft_bus_scheduler_if.sv | 28 ++
 rtl/ft_bus_scheduler_tx_fifo.sv | 73 +++++++
 rtl/ft_bus_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_ft_bus_scheduler.sv | 390 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ft_bus_scheduler_pkg.sv
// ft_pkg -- shared definitions for the FT240X bus scheduler slice.
//   * default values for strobe, recovery and TX buffer parameters
//   * scheduler state encoding (ft_state_e)
//   * served-direction type for round-robin arbitration (ft_dir_e)
//   * cyc_cnt_width(): width of the down-counter that times strobes/recovery
package ft_pkg;

    localparam int RD_LOW_CYC_DEF  = 2;
    localparam int WR_LOW_CYC_DEF  = 2;
    localparam int RECOVER_CYC_DEF = 2;
    localparam int TX_DEPTH_DEF    = 4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD_LOW   = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_LOW   = 3'd3,
        ST_RECOVER  = 3'd4
    } ft_state_e;

    typedef enum logic {
        DIR_RX = 1'b0,
        DIR_TX = 1'b1
    } ft_dir_e;

    // The timing counter is loaded with (cycles - 1) and counts down to zero,
    // so it only needs to hold the largest of the three values minus one.
    function automatic int cyc_cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 3) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/ft_bus_scheduler_if.sv
// ft_bus_scheduler_if -- user-side stream interface of the FT240X scheduler.
//   rx_valid / rx_data / rx_ready : received-byte handshake (scheduler -> user)
//   tx_push / tx_data             : enqueue a byte for transmission
//   tx_full                       : TX buffer holds its full capacity
//   tx_overflow / tx_overflow_clr : sticky dropped-push flag and its clear
// Modports: master = user logic, slave = the scheduler.
interface ft_bus_scheduler_if;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       tx_push;
    logic [7:0] tx_data;
    logic       tx_full;
    logic       tx_overflow;
    logic       tx_overflow_clr;

    modport master (
        input  rx_valid, rx_data, tx_full, tx_overflow,
        output rx_ready, tx_push, tx_data, tx_overflow_clr
    );

    modport slave (
        output rx_valid, rx_data, tx_full, tx_overflow,
        input  rx_ready, tx_push, tx_data, tx_overflow_clr
    );

endinterface

// File: rtl/ft_bus_scheduler_tx_fifo.sv
// ft_tx_fifo -- byte FIFO buffering data for the FT240X write path.
// Ports:
//   clk24MHz, nRST   : system clock, asynchronous active-low reset
//   push, push_data  : enqueue; ignored (and overflow raised) when full
//   pop              : drop the head entry; ignored when empty
//   overflow_clr     : clear the sticky overflow flag
//   head             : current head entry (valid when !empty)
//   full, empty      : occupancy flags
//   overflow         : sticky, set when a push was dropped
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter. DEPTH must be a power of two >= 2.
module ft_tx_fifo
    import ft_pkg::*;
#(
    parameter int DEPTH = TX_DEPTH_DEF
) (
    input  logic       clk24MHz,
    input  logic       nRST,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    input  logic       overflow_clr,
    output logic [7:0] head,
    output logic       full,
    output logic       empty,
    output logic       overflow
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W:0] wr_ptr;
    logic [IDX_W:0] rd_ptr;
    logic [7:0]     mem [DEPTH];
    logic           do_push;
    logic           do_pop;

    assign full    = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) &&
                     (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    // Fullness is judged before any same-cycle pop: a push into a full
    // buffer is always dropped.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[IDX_W-1:0]];

    // NOTE: the storage array has no reset; the pointers alone decide which
    // entries are valid, so clearing the data would only cost reset fan-out.
    always_ff @(posedge clk24MHz) begin
        if (do_push) begin
            mem[wr_ptr[IDX_W-1:0]] <= push_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk24MHz or negedge nRST) begin
        if (!nRST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            // An overflowing push outranks a coincident clear.
            if (push && full) begin
                overflow <= 1'b1;
            end else if (overflow_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ft_bus_scheduler.sv
// ft_bus_scheduler -- half-duplex scheduler for the FT240X parallel FIFO bus.
// Ports:
//   clk24MHz                   : system clock, all logic on its rising edge
//   nRST                       : asynchronous active-low reset
//   ft240x_d                   : bidirectional data bus, driven only while writing
//   ft240x_nRD, ft240x_nWR     : active-low read / write strobes
//   ft240x_RXF, ft240x_TXE     : asynchronous FT240X status (RX empty / TX full)
//   usr                        : user-side stream interface (slave modport)
// Reads and writes are arbitrated round-robin in IDLE; every strobe is
// followed by a recovery period with the bus released. Strobes and the bus
// enable are registered so the pins never glitch, and they are reset
// asynchronously so a reset aborts a transfer immediately.
module ft_bus_scheduler
    import ft_pkg::*;
#(
    parameter int RD_LOW_CYC  = RD_LOW_CYC_DEF,
    parameter int WR_LOW_CYC  = WR_LOW_CYC_DEF,
    parameter int RECOVER_CYC = RECOVER_CYC_DEF,
    parameter int TX_DEPTH    = TX_DEPTH_DEF
) (
    input  logic              clk24MHz,
    input  logic              nRST,
    inout  wire  [7:0]        ft240x_d,
    output logic              ft240x_nRD,
    output logic              ft240x_nWR,
    input  logic              ft240x_RXF,
    input  logic              ft240x_TXE,
    ft_bus_scheduler_if.slave usr
);

    localparam int CNT_W = cyc_cnt_width(RD_LOW_CYC, WR_LOW_CYC, RECOVER_CYC);

    logic [1:0]       rxf_sync;
    logic [1:0]       txe_sync;
    logic             rxf_s;
    logic             txe_s;

    ft_state_e        state;
    ft_state_e        state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    ft_dir_e          last_served;
    ft_dir_e          last_served_n;

    logic             rx_req;
    logic             tx_req;
    logic             rx_capture;
    logic             rx_valid;
    logic [7:0]       rx_data;
    logic             d_oe;

    logic             fifo_pop;
    logic [7:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_overflow;

    // Status pins are asynchronous to clk24MHz; they reset to the "nothing
    // to do" level (RX empty, TX full) so no transfer starts out of reset.
    always_ff @(posedge clk24MHz or negedge nRST) begin
        if (!nRST) begin
            rxf_sync <= 2'b11;
            txe_sync <= 2'b11;
        end else begin
            rxf_sync <= {rxf_sync[0], ft240x_RXF};
            txe_sync <= {txe_sync[0], ft240x_TXE};
        end
    end

    assign rxf_s = rxf_sync[1];
    assign txe_s = txe_sync[1];

    ft_tx_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk24MHz     (clk24MHz),
        .nRST         (nRST),
        .push         (usr.tx_push),
        .push_data    (usr.tx_data),
        .pop          (fifo_pop),
        .overflow_clr (usr.tx_overflow_clr),
        .head         (fifo_head),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .overflow     (fifo_overflow)
    );

    // A read is only requested while the previous byte has been consumed;
    // a write only while the device reports space.
    assign rx_req = !rxf_s && !rx_valid;
    assign tx_req = !fifo_empty && !txe_s;

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        last_served_n = last_served;
        fifo_pop      = 1'b0;
        rx_capture    = 1'b0;

        if (cnt != '0) begin
            cnt_n = cnt - 1'b1;
        end

        unique case (state)
            ST_IDLE: begin
                // On a tie the direction not served last wins.
                if (rx_req && (!tx_req || last_served == DIR_TX)) begin
                    state_n       = ST_RD_LOW;
                    cnt_n         = CNT_W'(RD_LOW_CYC - 1);
                    last_served_n = DIR_RX;
                end else if (tx_req) begin
                    state_n       = ST_WR_SETUP;
                    last_served_n = DIR_TX;
                end
            end
            ST_RD_LOW: begin
                if (cnt == '0) begin
                    rx_capture = 1'b1;
                    state_n    = ST_RECOVER;
                    cnt_n      = CNT_W'(RECOVER_CYC - 1);
                end
            end
            ST_WR_SETUP: begin
                state_n = ST_WR_LOW;
                cnt_n   = CNT_W'(WR_LOW_CYC - 1);
            end
            ST_WR_LOW: begin
                // The head stays on the bus for the whole low phase and is
                // released from the buffer only as the strobe rises.
                if (cnt == '0) begin
                    fifo_pop = 1'b1;
                    state_n  = ST_RECOVER;
                    cnt_n    = CNT_W'(RECOVER_CYC - 1);
                end
            end
            ST_RECOVER: begin
                if (cnt == '0) begin
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Pin levels are registered from the next state, so they match the
    // state register exactly while coming straight from flops.
    always_ff @(posedge clk24MHz or negedge nRST) begin
        if (!nRST) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            last_served <= DIR_TX;
            ft240x_nRD  <= 1'b1;
            ft240x_nWR  <= 1'b1;
            d_oe        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            last_served <= last_served_n;
            ft240x_nRD  <= (state_n != ST_RD_LOW);
            ft240x_nWR  <= (state_n != ST_WR_LOW);
            d_oe        <= (state_n == ST_WR_SETUP) || (state_n == ST_WR_LOW);
        end
    end

    // The byte is captured on the edge closing the last low cycle, which is
    // also the edge that raises nRD and flags it valid.
    always_ff @(posedge clk24MHz or negedge nRST) begin
        if (!nRST) begin
            rx_valid <= 1'b0;
            rx_data  <= 8'h00;
        end else if (rx_capture) begin
            rx_valid <= 1'b1;
            rx_data  <= ft240x_d;
        end else if (rx_valid && usr.rx_ready) begin
            rx_valid <= 1'b0;
        end
    end

    assign ft240x_d        = d_oe ? fifo_head : 8'hzz;

    assign usr.rx_valid    = rx_valid;
    assign usr.rx_data     = rx_data;
    assign usr.tx_full     = fifo_full;
    assign usr.tx_overflow = fifo_overflow;

endmodule

// File: tb/tb_ft_bus_scheduler.sv
// tb_ft_bus_scheduler -- self-checking bench for ft_bus_scheduler.
// An FT240X device model answers reads with random bytes; a monitor on the
// falling clock edge keeps a reference model of the TX buffer (occupancy,
// overflow, byte order) and of the received-byte stream, and checks strobe
// timing rules on every cycle. Directed phases precede a random phase.
module tb_ft_bus_scheduler;
    import ft_pkg::*;

    localparam int RD_LOW_CYC  = 2;
    localparam int WR_LOW_CYC  = 2;
    localparam int RECOVER_CYC = 2;
    localparam int TX_DEPTH    = 4;

    logic       clk24MHz = 1'b0;
    logic       nRST     = 1'b1;
    wire  [7:0] ft_d;
    logic       ft_nRD;
    logic       ft_nWR;
    logic       ft_RXF   = 1'b1;
    logic       ft_TXE   = 1'b1;
    logic [7:0] ft_rx_byte = 8'hA5;

    ft_bus_scheduler_if usr ();

    ft_bus_scheduler #(
        .RD_LOW_CYC  (RD_LOW_CYC),
        .WR_LOW_CYC  (WR_LOW_CYC),
        .RECOVER_CYC (RECOVER_CYC),
        .TX_DEPTH    (TX_DEPTH)
    ) dut (
        .clk24MHz   (clk24MHz),
        .nRST       (nRST),
        .ft240x_d   (ft_d),
        .ft240x_nRD (ft_nRD),
        .ft240x_nWR (ft_nWR),
        .ft240x_RXF (ft_RXF),
        .ft240x_TXE (ft_TXE),
        .usr        (usr)
    );

    // Device model drives the bus only while the read strobe is low.
    assign ft_d = (!ft_nRD) ? ft_rx_byte : 8'hzz;

    always #5 clk24MHz = ~clk24MHz;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model and monitor state ----------------
    logic [7:0] tx_exp[$];
    logic [7:0] rx_exp[$];
    bit         strobe_log[$];   // 0 = read, 1 = write, in start order
    int         m_cnt      = 0;
    bit         m_ovf      = 1'b0;
    bit         m_full;
    bit         pop_now;
    int         rd_run     = 0;
    int         wr_run     = 0;
    int         gap        = RECOVER_CYC;
    int         txe_run    = 0;
    int         rxf_run    = 0;
    int         rx_count   = 0;
    int         wr_count   = 0;
    bit         prev_ack   = 1'b0;
    bit         prev_wait  = 1'b0;
    bit         prev_d_oe  = 1'b0;
    logic [7:0] prev_d     = 8'h00;
    logic [7:0] held_rx    = 8'h00;
    logic [7:0] wr_byte    = 8'h00;

    always @(negedge clk24MHz) begin
        txe_run = ft_TXE ? txe_run + 1 : 0;
        rxf_run = ft_RXF ? rxf_run + 1 : 0;
        if (!nRST) begin
            tx_exp.delete();
            rx_exp.delete();
            strobe_log.delete();
            m_cnt     = 0;
            m_ovf     = 1'b0;
            rd_run    = 0;
            wr_run    = 0;
            gap       = RECOVER_CYC;
            prev_ack  = 1'b0;
            prev_wait = 1'b0;
            prev_d_oe = 1'b0;
        end else begin
            pop_now = 1'b0;
            check("strobe_overlap", 32'(ft_nRD | ft_nWR), 32'd1);
            check("bus_held_after_write", 32'(dut.d_oe && ft_nWR && prev_d_oe), 32'd0);

            // read strobe
            if (!ft_nRD) begin
                rd_run++;
                check("bus_driven_during_read", 32'(dut.d_oe), 32'd0);
                check("read_while_rx_valid", 32'(usr.rx_valid), 32'd0);
                if (rd_run == 1) begin
                    check("recovery_before_read", 32'(gap >= RECOVER_CYC), 32'd1);
                    check("read_while_rxf_high", 32'(rxf_run < 4), 32'd1);
                    strobe_log.push_back(1'b0);
                end
            end else if (rd_run > 0) begin
                check("nrd_low_cycles", 32'(rd_run), 32'(RD_LOW_CYC));
                rx_exp.push_back(ft_rx_byte);
                ft_rx_byte = 8'($urandom);
                rd_run = 0;
                gap    = 0;
            end

            // write strobe
            if (!ft_nWR) begin
                wr_run++;
                if (wr_run == 1) begin
                    check("recovery_before_write", 32'(gap >= RECOVER_CYC), 32'd1);
                    check("write_while_txe_high", 32'(txe_run < 5), 32'd1);
                    check("write_setup_cycle", 32'(prev_d_oe), 32'd1);
                    check("write_setup_data", 32'(ft_d), 32'(prev_d));
                    strobe_log.push_back(1'b1);
                    wr_byte = ft_d;
                end else begin
                    check("write_data_held", 32'(ft_d), 32'(wr_byte));
                end
                if (wr_run == WR_LOW_CYC) begin
                    if (tx_exp.size() == 0) begin
                        check("unexpected_write", 32'd1, 32'd0);
                    end else begin
                        check("write_byte", 32'(ft_d), 32'(tx_exp.pop_front()));
                        pop_now = 1'b1;
                    end
                    wr_count++;
                end
            end else if (wr_run > 0) begin
                check("nwr_low_cycles", 32'(wr_run), 32'(WR_LOW_CYC));
                wr_run = 0;
                gap    = 0;
            end

            if (ft_nRD && ft_nWR && rd_run == 0 && wr_run == 0) gap++;

            // TX buffer model
            check("tx_full", 32'(usr.tx_full), 32'(m_cnt == TX_DEPTH));
            check("tx_overflow", 32'(usr.tx_overflow), 32'(m_ovf));
            m_full = (m_cnt == TX_DEPTH);
            if (usr.tx_push && m_full) begin
                m_ovf = 1'b1;
            end else if (usr.tx_overflow_clr) begin
                m_ovf = 1'b0;
            end
            if (usr.tx_push && !m_full) begin
                tx_exp.push_back(usr.tx_data);
                m_cnt++;
            end
            if (pop_now) m_cnt--;

            // received-byte stream
            if (prev_wait) begin
                check("rx_valid_held", 32'(usr.rx_valid), 32'd1);
                check("rx_data_stable", 32'(usr.rx_data), 32'(held_rx));
            end
            if (prev_ack) begin
                check("rx_valid_clears", 32'(usr.rx_valid), 32'd0);
            end
            if (usr.rx_valid && usr.rx_ready) begin
                if (rx_exp.size() == 0) begin
                    check("unexpected_rx_byte", 32'd1, 32'd0);
                end else begin
                    check("rx_byte", 32'(usr.rx_data), 32'(rx_exp.pop_front()));
                end
                rx_count++;
            end
            prev_ack  = usr.rx_valid && usr.rx_ready;
            prev_wait = usr.rx_valid && !usr.rx_ready;
            held_rx   = usr.rx_data;
            prev_d_oe = dut.d_oe;
            prev_d    = ft_d;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cycle();
        @(posedge clk24MHz);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic push(input logic [7:0] b, input bit clr);
        cycle();
        usr.tx_push         = 1'b1;
        usr.tx_data         = b;
        usr.tx_overflow_clr = clr;
    endtask

    task automatic push_end();
        cycle();
        usr.tx_push         = 1'b0;
        usr.tx_overflow_clr = 1'b0;
    endtask

    task automatic wait_rx(input int target, input int budget);
        int n = 0;
        while (rx_count < target && n < budget) begin
            cycle();
            n++;
        end
        check("rx_wait_budget", 32'(rx_count >= target), 32'd1);
    endtask

    task automatic wait_wr(input int target, input int budget);
        int n = 0;
        while (wr_count < target && n < budget) begin
            cycle();
            n++;
        end
        check("write_wait_budget", 32'(wr_count >= target), 32'd1);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((tx_exp.size() != 0 || rx_exp.size() != 0 || usr.rx_valid) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_budget", 32'(tx_exp.size() + rx_exp.size()), 32'd0);
    endtask

    task automatic do_reset(input int n);
        nRST = 1'b0;
        idle(n);
        nRST = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;
        usr.rx_ready        = 1'b1;
        usr.tx_push         = 1'b0;
        usr.tx_data         = 8'h00;
        usr.tx_overflow_clr = 1'b0;

        // Asynchronous reset, checked before any clock edge.
        #1 nRST = 1'b0;
        #1;
        check("reset_nrd", 32'(ft_nRD), 32'd1);
        check("reset_nwr", 32'(ft_nWR), 32'd1);
        check("reset_bus_released", 32'(dut.d_oe), 32'd0);
        check("reset_rx_valid", 32'(usr.rx_valid), 32'd0);
        check("reset_rx_data", 32'(usr.rx_data), 32'h00);
        check("reset_tx_full", 32'(usr.tx_full), 32'd0);
        check("reset_tx_overflow", 32'(usr.tx_overflow), 32'd0);
        idle(3);
        nRST = 1'b1;

        // Single reads: first byte 0xA5, then one more with RXF still low.
        ft_RXF = 1'b0;
        wait_rx(2, 60);
        ft_RXF = 1'b1;
        idle(6);

        // Fill to full with TXE high, fifth push dropped, then drain in order.
        push(8'h11, 1'b0);
        push(8'h22, 1'b0);
        push(8'h33, 1'b0);
        push(8'h44, 1'b0);
        push(8'h55, 1'b0);
        push_end();
        idle(6);
        base   = wr_count;
        ft_TXE = 1'b0;
        wait_wr(base + 4, 80);
        idle(15);

        // Clear coincident with an overflowing push keeps the flag; clear alone drops it.
        ft_TXE = 1'b1;
        idle(4);
        for (int i = 0; i < TX_DEPTH; i++) push(8'(8'hC0 + i), 1'b0);
        push(8'hEE, 1'b1);
        cycle();
        usr.tx_push         = 1'b0;
        usr.tx_overflow_clr = 1'b1;
        push_end();
        idle(3);
        base   = wr_count;
        ft_TXE = 1'b0;
        wait_wr(base + TX_DEPTH, 100);
        idle(6);

        // Back-pressure: byte held while rx_ready is low, no further read.
        usr.rx_ready = 1'b0;
        ft_RXF       = 1'b0;
        n = 0;
        while (!usr.rx_valid && n < 40) begin
            cycle();
            n++;
        end
        check("rx_valid_under_backpressure", 32'(usr.rx_valid), 32'd1);
        base = rx_count;
        idle(20);
        usr.rx_ready = 1'b1;
        wait_rx(base + 2, 60);
        ft_RXF = 1'b1;
        idle(6);

        // Reset during the second low cycle of a write.
        push(8'h99, 1'b0);
        push(8'h9A, 1'b0);
        push_end();
        n = 0;
        while (ft_nWR && n < 60) begin
            @(negedge clk24MHz);
            n++;
        end
        check("write_started", 32'(ft_nWR), 32'd0);
        cycle();
        nRST = 1'b0;
        #1;
        check("abort_nwr_released", 32'(ft_nWR), 32'd1);
        check("abort_bus_released", 32'(dut.d_oe), 32'd0);
        idle(2);
        nRST = 1'b1;
        base = wr_count;
        idle(12);
        check("no_write_after_abort", 32'(wr_count - base), 32'd0);
        check("abort_tx_full", 32'(usr.tx_full), 32'd0);

        // Round-robin after reset: RXF low and buffer loaded with 0x77.
        nRST   = 1'b0;
        ft_RXF = 1'b0;
        ft_TXE = 1'b0;
        idle(2);
        nRST        = 1'b1;
        usr.tx_push = 1'b1;
        usr.tx_data = 8'h77;
        idle(TX_DEPTH);
        usr.tx_push = 1'b0;
        n = 0;
        while (strobe_log.size() < 4 && n < 80) begin
            cycle();
            n++;
        end
        check("rr_strobe_count", 32'(strobe_log.size() >= 4), 32'd1);
        if (strobe_log.size() >= 4) begin
            check("rr_order_0_read", 32'(strobe_log[0]), 32'd0);
            check("rr_order_1_write", 32'(strobe_log[1]), 32'd1);
            check("rr_order_2_read", 32'(strobe_log[2]), 32'd0);
            check("rr_order_3_write", 32'(strobe_log[3]), 32'd1);
        end
        ft_RXF = 1'b1;
        wait_drain(100);

        // Random traffic against the reference model.
        repeat (1500) begin
            cycle();
            if ($urandom_range(0, 7) == 0) ft_RXF = ~ft_RXF;
            if ($urandom_range(0, 9) == 0) ft_TXE = ~ft_TXE;
            usr.rx_ready        = ($urandom_range(0, 3) != 0);
            usr.tx_push         = ($urandom_range(0, 2) == 0);
            usr.tx_data         = 8'($urandom);
            usr.tx_overflow_clr = ($urandom_range(0, 15) == 0);
        end
        cycle();
        usr.tx_push         = 1'b0;
        usr.tx_overflow_clr = 1'b0;
        usr.rx_ready        = 1'b1;
        ft_RXF              = 1'b1;
        ft_TXE              = 1'b0;
        wait_drain(200);
        idle(10);
        check("final_tx_full", 32'(usr.tx_full), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
